// File: rtl/snes_pad_pkg.sv
// Shared constants for the SNES pad poller: button bit positions, frame length and FSM encoding.
package snes_pad_pkg;

  localparam int SNES_BITS = 16;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/snes_pad_poller_sync_ff2.sv
// Two-flop synchroniser; resets to 1 so the active-low pad line reads as released.
module sync_ff2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snes_pad_poller.sv
// SNES pad initiator: periodic latch + 16 clocks, parallel active-high button word out.
// Optional SNES_ID_CHECK_EN: reject frames whose ID nibble (bits 15:12) is not all released.
module snes_pad_poller
  import snes_pad_pkg::*;
#(
  parameter int HALF_CYC = 300,
  parameter int POLL_CYC = 833333
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snes_data,
  output logic        snes_latch,
  output logic        snes_clk,
  output logic [11:0] snes_button,
  output logic        frame_done,
  output logic        present,
  output logic [2:0]  fsm_state
);

  localparam int PW = $clog2(POLL_CYC);
  localparam int TW = $clog2(2 * HALF_CYC);

  // Handshake: none; snes_button is valid whenever frame_done pulses and holds until the next pulse.

  logic [PW-1:0] poll_cnt;
  logic          strobe;
  logic          data_sync;
  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    bit_cnt;
  logic [11:0]   shift;
`ifdef SNES_ID_CHECK_EN
  logic [3:0]    id_bits;
`endif

  assign strobe    = (poll_cnt == PW'(POLL_CYC - 1));
  assign fsm_state = state;

  sync_ff2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (snes_data),
    .q   (data_sync)
  );

  always_ff @(posedge clk) begin
    if (rst || strobe) poll_cnt <= '0;
    else               poll_cnt <= poll_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
`ifdef SNES_ID_CHECK_EN
      id_bits     <= '0;
`endif
      snes_latch  <= 1'b0;
      snes_clk    <= 1'b1;
      snes_button <= '0;
      frame_done  <= 1'b0;
      present     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            state      <= LATCH;
            snes_latch <= 1'b1;
            timer      <= '0;
            bit_cnt    <= '0;
          end
        end
        LATCH: begin
          if (timer == TW'(2 * HALF_CYC - 1)) begin
            state      <= LOW;
            snes_latch <= 1'b0;
            snes_clk   <= 1'b0;
            timer      <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LOW: begin
          // Sample just before the rising pad clock; the pad shifts on that edge.
          if (timer == TW'(HALF_CYC - 1)) begin
            if (bit_cnt < 4'd12) shift[bit_cnt] <= ~data_sync;
`ifdef SNES_ID_CHECK_EN
            else                 id_bits[bit_cnt[1:0]] <= ~data_sync;
`endif
            state    <= HIGH;
            snes_clk <= 1'b1;
            timer    <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HIGH: begin
          if (timer == TW'(HALF_CYC - 1)) begin
            timer <= '0;
            if (bit_cnt == 4'(SNES_BITS - 1)) begin
              state      <= DONE;
              frame_done <= 1'b1;
`ifdef SNES_ID_CHECK_EN
              if (id_bits == 4'b0000) begin
                snes_button <= shift;
                present     <= 1'b1;
              end else begin
                snes_button <= '0;
                present     <= 1'b0;
              end
`else
              snes_button <= shift;
              present     <= 1'b1;
`endif
            end else begin
              state    <= LOW;
              snes_clk <= 1'b0;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snes_pad_poller.sv
// Directed bench for snes_pad_poller with a behavioural pad that shifts on rising snes_clk.
`timescale 1ns/1ps
module tb_snes_pad_poller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snes_data;
  logic        snes_latch;
  logic        snes_clk;
  logic [11:0] snes_button;
  logic        frame_done;
  logic        present;
  logic [2:0]  fsm_state;

  logic [15:0] pad_word = 16'hFFFF;
  logic [15:0] pad_sr = 16'hFFFF;
  logic        tie0 = 1'b0;

  int total = 0;
  int bad = 0;
  int viol = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  snes_pad_poller #(.HALF_CYC(4), .POLL_CYC(200)) dut (
    .clk         (clk),
    .rst         (rst),
    .snes_data   (snes_data),
    .snes_latch  (snes_latch),
    .snes_clk    (snes_clk),
    .snes_button (snes_button),
    .frame_done  (frame_done),
    .present     (present),
    .fsm_state   (fsm_state)
  );

  // Pad: latch loads the wire word (0 = pressed), each rising clk shifts the next bit out.
  always @(posedge snes_clk or posedge snes_latch) begin
    if (snes_latch) pad_sr <= pad_word;
    else            pad_sr <= {1'b1, pad_sr[15:1]};
  end
  assign snes_data = tie0 ? 1'b0 : pad_sr[0];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs until frame_done (bounded), measuring latch width, falling clk edges and frame span.
  task automatic wait_frame(output int lat_cyc, output int falls, output int first_lat,
                            output int span, output bit got);
    logic prev_clk;
    lat_cyc = 0; falls = 0; first_lat = -1; span = 0; got = 1'b0;
    prev_clk = snes_clk;
    for (int i = 1; i <= 450; i++) begin
      @(posedge clk); #1;
      if (snes_latch && !snes_clk) viol++;
      if (snes_latch) begin
        lat_cyc++;
        if (first_lat < 0) first_lat = i;
      end
      if (prev_clk && !snes_clk) falls++;
      prev_clk = snes_clk;
      if (frame_done) begin
        got = 1'b1;
        span = i - first_lat;
        break;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] wire_word, input logic [11:0] exp_btn,
                           input logic exp_present);
    int lat_cyc, falls, first_lat, span;
    bit got;
    pad_word = wire_word;
    exp_q.push_back(exp_btn);
    wait_frame(lat_cyc, falls, first_lat, span, got);
    check({tag, "_done_seen"}, 16'(got), 16'd1);
    check({tag, "_button"}, 16'(snes_button), 16'(exp_q.pop_front()));
    check({tag, "_present"}, 16'(present), 16'(exp_present));
    check({tag, "_falls"}, 16'(falls), 16'd16);
    check({tag, "_span"}, 16'(span), 16'd136);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 16'(frame_done), 16'd0);
  endtask

  initial begin
    int lat_cyc, falls, first_lat, span, idle_bad, fd_seen;
    bit got;

    repeat (3) @(posedge clk);
    #1;
    check("rst_latch", 16'(snes_latch), 16'd0);
    check("rst_clk", 16'(snes_clk), 16'd1);
    check("rst_button", 16'(snes_button), 16'd0);
    check("rst_done", 16'(frame_done), 16'd0);
    check("rst_present", 16'(present), 16'd0);
    check("rst_state", 16'(fsm_state), 16'd0);

    // Frame 1: only A pressed; also pins the first strobe position and latch width.
    @(negedge clk); rst = 1'b0;
    pad_word = 16'hFEFF;
    idle_bad = 0;
    for (int i = 1; i <= 199; i++) begin
      @(posedge clk); #1;
      if (snes_latch || !snes_clk) idle_bad++;
    end
    check("idle_pins", 16'(idle_bad), 16'd0);
    wait_frame(lat_cyc, falls, first_lat, span, got);
    check("f1_latch_edge", 16'(first_lat), 16'd1);
    check("f1_latch_len", 16'(lat_cyc), 16'd8);
    check("f1_done_seen", 16'(got), 16'd1);
    check("f1_button", 16'(snes_button), 16'h100);
    check("f1_present", 16'(present), 16'd1);
    check("f1_falls", 16'(falls), 16'd16);
    check("f1_span", 16'(span), 16'd136);
    @(posedge clk); #1;
    check("f1_done_pulse", 16'(frame_done), 16'd0);

    repeat (50) @(posedge clk);
    #1;
    check("hold_button", 16'(snes_button), 16'h100);

    run_frame("f2", 16'hF7F6, 12'h809, 1'b1);
    run_frame("f3", 16'hFFFF, 12'h000, 1'b1);
    run_frame("f4", 16'hF7F6, 12'h809, 1'b1);

    // Reset in the 5th LOW phase of the next frame.
    falls = 0;
    begin
      logic prev_clk;
      prev_clk = snes_clk;
      for (int i = 0; i < 450 && falls < 5; i++) begin
        @(posedge clk); #1;
        if (prev_clk && !snes_clk) falls++;
        prev_clk = snes_clk;
      end
    end
    check("mid_reached_low5", 16'(falls), 16'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_latch", 16'(snes_latch), 16'd0);
    check("mid_clk", 16'(snes_clk), 16'd1);
    check("mid_button", 16'(snes_button), 16'd0);
    check("mid_done", 16'(frame_done), 16'd0);
    check("mid_present", 16'(present), 16'd0);
    @(negedge clk); rst = 1'b0;
    fd_seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (frame_done) fd_seen++;
    end
    check("mid_no_done", 16'(fd_seen), 16'd0);
    run_frame("post_rst", 16'hFEFF, 12'h100, 1'b1);

    // Data stuck low: every bit reads pressed, including the ID nibble.
    tie0 = 1'b1;
`ifdef SNES_ID_CHECK_EN
    run_frame("tie0", 16'hFFFF, 12'h000, 1'b0);
    tie0 = 1'b0;
    run_frame("restore", 16'hF7F6, 12'h809, 1'b1);
`else
    run_frame("tie0", 16'hFFFF, 12'hFFF, 1'b1);
    tie0 = 1'b0;
    run_frame("restore", 16'hFFFF, 12'h000, 1'b1);
`endif

    check("latch_clk_overlap", 16'(viol), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
